band_ptt_arbiter: RTL and testbench
===================================

# band_ptt_arbiter

Front-end PTT arbiter and band scheduler for the transverter sequencers. It debounces several active-low PTT sources and grants the shared transmit path to one source at a time. It routes the granted PTT to the sequencer of the currently active band and allows band changes only while every sequencer is back in receive. It also enforces inter-transmission guard time and an optional transmit timeout.

## Interface
- NUM_SRC, 3: number of PTT sources (footswitch, CAT, radio).
- NUM_BANDS, 2: number of band sequencers driven.
- BAND_W, 1: width of band_req/active_band.
- DEBOUNCE_CYCLES, 500000: consecutive stable samples required to change a debounced source.
- GUARD_CYCLES, 4000000: hold-off after PTT release or band switch; must exceed the full sequencer key-up plus key-down time.
- TOT_CYCLES, 3000000000: transmit timeout.
- CNT_W, 32: width of guard and TOT counters; all cycle parameters must fit.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- ptt_n_in  in  NUM_SRC  raw asynchronous PTT sources, 0 = transmit request.
- band_req  in  BAND_W  requested band; values >= NUM_BANDS are ignored.
- ptt_n_out  out  NUM_BANDS  per-sequencer PTT, 0 = transmit; at most one bit is low.
- active_band  out  BAND_W  band currently routed.
- src_grant  out  NUM_SRC  one-hot granted source, 0 when none.
- busy  out  1  high whenever state != IDLE.
- tot_expired  out  1  high while in LOCKOUT.

## Operation
- Each source is synchronized with 2 flops, then debounced. The debounced value changes only after the synchronized value has differed from it on DEBOUNCE_CYCLES consecutive edges.
- FSM, one-hot: IDLE, SWITCH, TX, RELEASE, LOCKOUT.
- IDLE:
  - If band_req is valid and differs from active_band: go to SWITCH, set active_band to band_req, load guard with GUARD_CYCLES. This takes priority over requests.
  - Otherwise, if any debounced request is asserted: grant the lowest-index requester and go to TX.
- SWITCH: guard counts down; at 0 go to IDLE. Requests are held off.
- TX:
  - ptt_n_out[active_band]=0.
  - Other sources and band_req are ignored.
  - When the granted source's debounced request drops: go to RELEASE, load guard, clear src_grant.
- RELEASE: all ptt_n_out high; guard counts down; at 0 go to IDLE. A re-request does not retrigger the guard; it is served from IDLE.
- LOCKOUT: all ptt_n_out high, guard loaded on entry. Exit to IDLE only when guard==0 and no debounced request is asserted.
- Reset: state IDLE, active_band=0, ptt_n_out all 1, src_grant 0, busy 0, tot_expired 0, debouncers at released (1), counters 0.
- Reset mid-TX: ptt_n_out returns high on the reset edge. The downstream sequencer performs its own release.

## Timing
- Latency from an input edge to the debounced change is DEBOUNCE_CYCLES+2 clocks. ptt_n_out and src_grant change 1 clock later. The request-to-key latency is therefore DEBOUNCE_CYCLES+3 clocks.
- Release: ptt_n_out goes high 1 clock after the debounced drop.
- Guard: the state is left exactly GUARD_CYCLES+1 clocks after entry.
- Simultaneous requests in IDLE: the lowest index wins. A simultaneous band change plus request in IDLE results in SWITCH first.
- band_req changes during SWITCH, TX, RELEASE or LOCKOUT are sampled again only on return to IDLE.

## Configuration
- PTT_TOT_EN defined:
  - TOT counter clears on TX entry and increments each TX clock.
  - When it reaches TOT_CYCLES: go to LOCKOUT, clear src_grant.
- PTT_TOT_EN undefined:
  - No TOT counter or LOCKOUT logic.
  - TX is unlimited and tot_expired is tied to 0.

## Structure
- Package seq_pkg holds:
  - the one-hot state localparams (IDLE=5'b00001 … LOCKOUT=5'b10000);
  - the default cycle constants;
  - a priority-encode function for src_grant.
- Sub-module ptt_debounce (synchronizer plus counter, parameter DEBOUNCE_CYCLES) is instantiated NUM_SRC times.

## Test plan
Common parameters: DEBOUNCE_CYCLES=4, GUARD_CYCLES=10, TOT_CYCLES=100, NUM_SRC=3, NUM_BANDS=2.

- Basic key: source 0 low → ptt_n_out=2'b10 and src_grant=3'b001 exactly 7 clocks later. Release → ptt_n_out=2'b11 after 7 clocks; busy stays high for 11 more clocks.
- Glitch: source 1 low for 3 clocks → no change on any output.
- Contention: sources 2 and 1 low on the same clock → src_grant=3'b010. Source 2 still low after source 1 releases → granted only after RELEASE, 11 clocks later.
- Band switch: in IDLE, band_req=1 → active_band=1 next clock, busy high 11 clocks. A concurrent request then keys ptt_n_out=2'b01. band_req=2 has no effect.
- TOT (PTT_TOT_EN): hold source 0 → ptt_n_out returns to 2'b11 after 100 TX clocks and tot_expired=1 until 1 clock after release plus guard.
- Reset during TX → all outputs at reset values on the next edge; re-key requires the full 7-clock latency.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared types and defaults for the band PTT arbiter: one-hot FSM states,
// default cycle constants and the source priority encoder.
package seq_pkg;

   typedef enum logic [4:0] {
      IDLE    = 5'b00001,
      SWITCH  = 5'b00010,
      TX      = 5'b00100,
      RELEASE = 5'b01000,
      LOCKOUT = 5'b10000
   } state_t;

   localparam int unsigned DEF_DEBOUNCE_CYCLES = 32'd500000;
   localparam int unsigned DEF_GUARD_CYCLES    = 32'd4000000;
   localparam int unsigned DEF_TOT_CYCLES      = 32'd3000000000;

   localparam int MAX_SRC = 8;

   // Isolates the lowest set bit, so the lowest-index requester wins.
   function automatic logic [MAX_SRC-1:0] lowest_onehot(input logic [MAX_SRC-1:0] req);
      return req & (~req + MAX_SRC'(1));
   endfunction

endpackage

// File: rtl/ptt_debounce.sv
// Two-flop synchronizer plus consecutive-sample debouncer for one
// active-low PTT source; output rests at released (1) after reset.
module ptt_debounce
   import seq_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic reset,
   input  logic ptt_n_raw,
   output logic ptt_n_db
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync_p0;
   logic          sync_p1;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_p0  <= 1'b1;
         sync_p1  <= 1'b1;
         ptt_n_db <= 1'b1;
         cnt      <= '0;
      end else begin
         sync_p0 <= ptt_n_raw;
         sync_p1 <= sync_p0;
         // Any sample that agrees with the current output restarts the run.
         if (sync_p1 != ptt_n_db) begin
            if (cnt == LAST) begin
               ptt_n_db <= sync_p1;
               cnt      <= '0;
            end else begin
               cnt <= cnt + CW'(1);
            end
         end else begin
            cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/band_ptt_arbiter.sv
// PTT arbiter and band scheduler: grants one debounced source, keys the
// active band's sequencer, enforces guard time. `define PTT_TOT_EN adds timeout lockout.
module band_ptt_arbiter
   import seq_pkg::*;
#(
   parameter int          NUM_SRC         = 3,
   parameter int          NUM_BANDS       = 2,
   parameter int          BAND_W          = 1,
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int unsigned GUARD_CYCLES    = DEF_GUARD_CYCLES,
   parameter int unsigned TOT_CYCLES      = DEF_TOT_CYCLES,
   parameter int          CNT_W           = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_SRC-1:0]   ptt_n_in,
   input  logic [BAND_W-1:0]    band_req,
   output logic [NUM_BANDS-1:0] ptt_n_out,
   output logic [BAND_W-1:0]    active_band,
   output logic [NUM_SRC-1:0]   src_grant,
   output logic                 busy,
   output logic                 tot_expired
);

   localparam logic [CNT_W-1:0] GUARD_LD = CNT_W'(GUARD_CYCLES);

   if ((64'(GUARD_CYCLES) >= (64'd1 << CNT_W)) || (64'(TOT_CYCLES) >= (64'd1 << CNT_W))) begin : g_cnt_range
      $error("band_ptt_arbiter: cycle parameter does not fit in CNT_W");
   end

   logic [NUM_SRC-1:0] db_n;
   logic [NUM_SRC-1:0] req;

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_deb
      ptt_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
         .clk       (clk),
         .reset     (reset),
         .ptt_n_raw (ptt_n_in[i]),
         .ptt_n_db  (db_n[i])
      );
   end

   assign req = ~db_n;

   state_t             state_q, state_d;
   logic [BAND_W-1:0]  band_d;
   logic [NUM_SRC-1:0] grant_d;
   logic [CNT_W-1:0]   guard_q, guard_d;
   logic               band_ok;
`ifdef PTT_TOT_EN
   localparam logic [CNT_W-1:0] TOT_LD = CNT_W'(TOT_CYCLES);
   logic [CNT_W-1:0]   tot_q, tot_d;
`endif

   assign band_ok = int'(band_req) < NUM_BANDS;

   always_comb begin
      state_d = state_q;
      band_d  = active_band;
      grant_d = src_grant;
      guard_d = guard_q;
`ifdef PTT_TOT_EN
      tot_d   = tot_q;
`endif
      unique case (state_q)
         IDLE: begin
            // A pending band change always goes first, ahead of any request.
            if (band_ok && (band_req != active_band)) begin
               state_d = SWITCH;
               band_d  = band_req;
               guard_d = GUARD_LD;
            end else if (|req) begin
               state_d = TX;
               grant_d = NUM_SRC'(lowest_onehot(MAX_SRC'(req)));
`ifdef PTT_TOT_EN
               tot_d   = '0;
`endif
            end
         end
         SWITCH, RELEASE: begin
            if (guard_q == '0) state_d = IDLE;
            else               guard_d = guard_q - CNT_W'(1);
         end
         TX: begin
            if ((req & src_grant) == '0) begin
               state_d = RELEASE;
               guard_d = GUARD_LD;
               grant_d = '0;
            end
`ifdef PTT_TOT_EN
            else if ((tot_q + CNT_W'(1)) == TOT_LD) begin
               state_d = LOCKOUT;
               guard_d = GUARD_LD;
               grant_d = '0;
            end else begin
               tot_d = tot_q + CNT_W'(1);
            end
`endif
         end
`ifdef PTT_TOT_EN
         LOCKOUT: begin
            // Stay locked until the guard has run out and every source has let go.
            if (guard_q != '0) guard_d = guard_q - CNT_W'(1);
            else if (!(|req))  state_d = IDLE;
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         active_band <= '0;
         src_grant   <= '0;
         guard_q     <= '0;
`ifdef PTT_TOT_EN
         tot_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         active_band <= band_d;
         src_grant   <= grant_d;
         guard_q     <= guard_d;
`ifdef PTT_TOT_EN
         tot_q       <= tot_d;
`endif
      end
   end

   always_comb begin
      ptt_n_out = '1;
      for (int b = 0; b < NUM_BANDS; b++) begin
         if ((state_q == TX) && (int'(active_band) == b)) ptt_n_out[b] = 1'b0;
      end
   end

   assign busy = (state_q != IDLE);
`ifdef PTT_TOT_EN
   assign tot_expired = (state_q == LOCKOUT);
`else
   assign tot_expired = 1'b0;
`endif

endmodule

// File: tb/tb_band_ptt_arbiter.sv
// Scoreboard bench for band_ptt_arbiter: a timestamp-based reference model
// predicts every output change; a negedge monitor checks them.
module tb_band_ptt_arbiter;

   localparam int DB   = 4;
   localparam int G    = 10;
   localparam int TOT  = 100;
   localparam int NS   = 3;
   localparam int NB   = 2;
   localparam int MAXC = 12000;

   logic          clk;
   logic          reset;
   logic [NS-1:0] ptt_n_in;
   logic [1:0]    band_req;
   logic [NB-1:0] ptt_n_out;
   logic [1:0]    active_band;
   logic [NS-1:0] src_grant;
   logic          busy;
   logic          tot_expired;

   band_ptt_arbiter #(
      .NUM_SRC(NS), .NUM_BANDS(NB), .BAND_W(2),
      .DEBOUNCE_CYCLES(DB), .GUARD_CYCLES(G), .TOT_CYCLES(TOT), .CNT_W(32)
   ) dut (
      .clk(clk), .reset(reset), .ptt_n_in(ptt_n_in), .band_req(band_req),
      .ptt_n_out(ptt_n_out), .active_band(active_band), .src_grant(src_grant),
      .busy(busy), .tot_expired(tot_expired)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      int         cyc;
      logic [8:0] vec;
      bit         rst;
   } ev_t;
   ev_t sb[$];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   bit done  = 0;

   // Reference model: modes 0 idle, 1 switch, 2 tx, 3 release, 4 lockout.
   bit         raw_h  [NS][MAXC];
   bit         samp_h [NS][MAXC];
   bit         mdb    [NS];
   int         lflip  [NS];
   int         last_rst = 0;
   int         mode = 0, mab = 0, mg = -1;
   int         leave_at = 0, tx_start = 0, lock_at = 0;
   logic [8:0] mprev;

   function automatic logic [8:0] mvec();
      logic [1:0] p;
      logic [2:0] g;
      logic [1:0] ab;
      p  = 2'b11;
      g  = 3'b000;
      ab = 2'(mab);
      if (mode == 2) p[mab] = 1'b0;
      if (mg >= 0)   g[mg]  = 1'b1;
      return {p, g, ab, (mode != 0), (mode == 4)};
   endfunction

   task automatic model_edge();
      bit anyreq;
      bit samp;
      bit ok;
      cyc++;
      for (int s = 0; s < NS; s++) raw_h[s][cyc] = ptt_n_in[s];
      if (reset) begin
         last_rst = cyc;
         for (int s = 0; s < NS; s++) begin
            mdb[s]   = 1'b1;
            lflip[s] = cyc;
         end
         mode  = 0;
         mab   = 0;
         mg    = -1;
         mprev = mvec();
         sb.push_back('{cyc, mprev, 1'b1});
         return;
      end
      anyreq = 1'b0;
      for (int s = 0; s < NS; s++) if (!mdb[s]) anyreq = 1'b1;
      case (mode)
         0: begin
            if ((int'(band_req) < NB) && (int'(band_req) != mab)) begin
               mode = 1;
               mab = int'(band_req);
               leave_at = cyc + G + 1;
            end else if (anyreq) begin
               for (int s = NS - 1; s >= 0; s--) if (!mdb[s]) mg = s;
               mode = 2;
               tx_start = cyc;
            end
         end
         1, 3: if (cyc == leave_at) mode = 0;
         2: begin
            if (mdb[mg]) begin
               mode = 3;
               mg = -1;
               leave_at = cyc + G + 1;
            end
`ifdef PTT_TOT_EN
            else if (cyc - tx_start == TOT) begin
               mode = 4;
               mg = -1;
               lock_at = cyc;
            end
`endif
         end
         4: if ((cyc >= lock_at + G + 1) && !anyreq) mode = 0;
         default: mode = 0;
      endcase
      // A source flips once D consecutive synchronized samples disagree with it.
      for (int s = 0; s < NS; s++) begin
         samp = (cyc - 2 > last_rst) ? raw_h[s][cyc-2] : 1'b1;
         samp_h[s][cyc] = samp;
         if (cyc - lflip[s] >= DB) begin
            ok = 1'b1;
            for (int k = cyc - DB + 1; k <= cyc; k++) if (samp_h[s][k] == mdb[s]) ok = 1'b0;
            if (ok) begin
               mdb[s]   = ~mdb[s];
               lflip[s] = cyc;
            end
         end
      end
      if (mvec() != mprev) begin
         mprev = mvec();
         sb.push_back('{cyc, mprev, 1'b0});
      end
   endtask

   task automatic run(input logic [2:0] p, input logic [1:0] b, input logic r, input int n);
      ptt_n_in = p;
      band_req = b;
      reset    = r;
      repeat (n) begin
         @(posedge clk);
         if (cyc < MAXC - 1) model_edge();
         #2;
      end
   endtask

   initial begin
      int         n;
      logic [1:0] b;
      logic [2:0] p;
      ptt_n_in = 3'b111;
      band_req = 2'd0;
      reset    = 1'b1;
      #2;
      run(3'b111, 2'd0, 1'b1, 3);
      run(3'b111, 2'd0, 1'b0, 5);
      // basic key and release on source 0
      run(3'b110, 2'd0, 1'b0, 20);
      run(3'b111, 2'd0, 1'b0, 30);
      // short glitch on source 1
      run(3'b101, 2'd0, 1'b0, 3);
      run(3'b111, 2'd0, 1'b0, 20);
      // contention between sources 2 and 1
      run(3'b001, 2'd0, 1'b0, 20);
      run(3'b011, 2'd0, 1'b0, 40);
      run(3'b111, 2'd0, 1'b0, 30);
      // band switch with a concurrent request, then an invalid band
      run(3'b110, 2'd1, 1'b0, 40);
      run(3'b111, 2'd1, 1'b0, 30);
      run(3'b111, 2'd2, 1'b0, 10);
      run(3'b110, 2'd2, 1'b0, 20);
      run(3'b111, 2'd2, 1'b0, 30);
      run(3'b111, 2'd0, 1'b0, 20);
`ifdef PTT_TOT_EN
      run(3'b110, 2'd0, 1'b0, 150);
      run(3'b111, 2'd0, 1'b0, 30);
`endif
      // reset while keyed, then re-key
      run(3'b110, 2'd0, 1'b0, 15);
      run(3'b110, 2'd0, 1'b1, 1);
      run(3'b110, 2'd0, 1'b0, 20);
      run(3'b111, 2'd0, 1'b0, 30);
      b = 2'd0;
      for (int i = 0; i < 150; i++) begin
         p = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 9) < 3) b = 2'($urandom_range(0, 3));
         n = $urandom_range(1, 25);
         run(p, b, 1'b0, n);
         if ($urandom_range(0, 49) == 0) run(p, b, 1'b1, 1);
      end
      run(3'b111, 2'd0, 1'b0, 40);
      @(negedge clk);
      @(negedge clk);
      done = 1'b1;
   end

   initial begin
      logic [8:0] dv;
      logic [8:0] last;
      bit         armed;
      bit         matched;
      ev_t        e;
      armed = 1'b0;
      last  = '0;
      while (!done) begin
         @(negedge clk);
         dv = {ptt_n_out, src_grant, active_band, busy, tot_expired};
         matched = 1'b0;
         while ((sb.size() > 0) && (sb[0].cyc <= cyc)) begin
            e = sb.pop_front();
            total++;
            if ((e.cyc != cyc) || (dv !== e.vec)) begin
               bad++;
               $display("FAIL %s cyc=%0d exp_cyc=%0d got={ptt,grant,band,busy,tot}=%b want=%b",
                        e.rst ? "reset_state" : "output_change", cyc, e.cyc, dv, e.vec);
            end
            matched = 1'b1;
         end
         if (!matched && armed && (dv !== last)) begin
            total++;
            bad++;
            $display("FAIL unexpected_change cyc=%0d got=%b want=%b", cyc, dv, last);
         end
         armed = armed | matched;
         last  = dv;
      end
      while (sb.size() > 0) begin
         e = sb.pop_front();
         total++;
         bad++;
         $display("FAIL unchecked_event exp_cyc=%0d got=none want=%b", e.cyc, e.vec);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
